// File: rtl/multdiv_sequencer_if.sv
// Operand/control/result bundle for the sequential multiply/divide unit.
// master drives operands and start pulses; slave returns result, flags and status.
interface multdiv_sequencer_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Sequential 32-bit signed multiplier (radix-4 Booth, 16 cycles) and
// restoring divider (32 cycles) sharing one 66-bit working register.
module multdiv_sequencer (
    input  logic                  clk,
    input  logic                  reset,
    multdiv_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg;
    logic [65:0] work_reg;
    logic [31:0] a_reg, b_reg;
    logic [31:0] result_reg;
    logic        exception_reg;

    logic        start;
    logic [31:0] a_mag, b_mag;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign a_mag = bus.data_operandA[31] ? (~bus.data_operandA + 32'd1) : bus.data_operandA;
    assign b_mag = b_reg[31] ? (~b_reg + 32'd1) : b_reg;

    // Booth step: sum is kept 35 bits wide because acc + 2M can exceed the 33-bit range
    logic [34:0] mcand, pp, booth_sum;
    logic [65:0] booth_next;
    always_comb begin
        mcand = {{3{a_reg[31]}}, a_reg};
        pp    = 35'd0;
        case (work_reg[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = ~(mcand << 1) + 35'd1;
            3'b101, 3'b110: pp = ~mcand + 35'd1;
            default:        pp = 35'd0;
        endcase
        booth_sum  = {{2{work_reg[65]}}, work_reg[65:33]} + pp;
        booth_next = {booth_sum[34:2], booth_sum[1:0], work_reg[32:2]};
    end

    // Restoring divide step: remainder in [65:33], quotient shifts in at [32:1]
    logic [32:0] div_shift, div_rem;
    logic [33:0] div_diff;
    logic        div_ge;
    logic [65:0] div_next;
    always_comb begin
        div_shift = {work_reg[64:33], work_reg[32]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
        div_ge    = ~div_diff[33];
        div_rem   = div_ge ? div_diff[32:0] : div_shift;
        div_next  = {div_rem, work_reg[31:1], div_ge, 1'b0};
    end

    logic [31:0] mul_result, div_result, quot;
    logic        mul_exc, div_exc, quot_neg;
    always_comb begin
        mul_result = work_reg[32:1];
        mul_exc    = work_reg[64:33] != {32{work_reg[32]}};
        quot       = work_reg[32:1];
        quot_neg   = a_reg[31] ^ b_reg[31];
        div_result = quot_neg ? (~quot + 32'd1) : quot;
        // a positive quotient with bit 31 set only arises from MIN / -1
        div_exc    = ~quot_neg & quot[31];
        if (b_reg == 32'd0) begin
            div_result = 32'd0;
            div_exc    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (start)
            state_next = bus.ctrl_MULT ? MUL : DIV;
        else begin
            case (state_reg)
                MUL:     if (cnt_reg == 6'd16) state_next = DONE;
                DIV:     if (cnt_reg == 6'd32) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.data_resultRDY = (state_reg == DONE);
        bus.busy           = (state_reg == MUL) || (state_reg == DIV);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg       <= 6'd0;
            work_reg      <= 66'd0;
            a_reg         <= 32'd0;
            b_reg         <= 32'd0;
            result_reg    <= 32'd0;
            exception_reg <= 1'b0;
        end else if (start) begin
            a_reg    <= bus.data_operandA;
            b_reg    <= bus.data_operandB;
            cnt_reg  <= 6'd0;
            work_reg <= bus.ctrl_MULT ? {33'd0, bus.data_operandB, 1'b0}
                                      : {33'd0, a_mag, 1'b0};
        end else begin
            case (state_reg)
                MUL: begin
                    if (cnt_reg == 6'd16) begin
                        result_reg    <= mul_result;
                        exception_reg <= mul_exc;
                    end else begin
                        work_reg <= booth_next;
                        cnt_reg  <= cnt_reg + 6'd1;
                    end
                end
                DIV: begin
                    if (cnt_reg == 6'd32) begin
                        result_reg    <= div_result;
                        exception_reg <= div_exc;
                    end else begin
                        work_reg <= div_next;
                        cnt_reg  <= cnt_reg + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_result    = result_reg;
    assign bus.data_exception = exception_reg;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: hand-computed products/quotients,
// strobe timing, abort-by-restart and asynchronous reset behaviour.
module tb_multdiv_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    multdiv_sequencer_if bus ();

    multdiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drives a start pulse so that the next rising edge is E0; returns #1 after E0.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clk);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'hDEADBEEF;
        bus.data_operandB = 32'h0BADF00D;
    endtask

    // Watches n edges; first = index of first edge with the strobe high, cnt = strobe count.
    task automatic watch(input int n, output int first, output int cnt);
        first = 0;
        cnt   = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (bus.data_resultRDY) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b, input int exp_edge,
                         input logic [31:0] exp_res, input logic exp_exc);
        int first, cnt;
        start_op(m, d, a, b);
        check({tag, " busy@E0"}, 32'(bus.busy), 32'd1);
        watch(exp_edge + 1, first, cnt);
        check({tag, " strobe_edge"}, 32'(first), 32'(exp_edge));
        check({tag, " strobe_count"}, 32'(cnt), 32'd1);
        check({tag, " result"}, bus.data_result, exp_res);
        check({tag, " exception"}, 32'(bus.data_exception), 32'(exp_exc));
        check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        $display("op %s A=%h B=%h -> result=%h exc=%0b strobe@E%0d", tag, a, b,
                 bus.data_result, bus.data_exception, first);
    endtask

    initial begin
        int first, cnt;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst result", bus.data_result, 32'd0);
        check("rst exception", 32'(bus.data_exception), 32'd0);
        check("rst rdy", 32'(bus.data_resultRDY), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op("mul 7*-3",        1, 0, 32'd7,          32'hFFFFFFFD, 17, 32'hFFFFFFEB, 1'b0);
        do_op("mul 2^30*4",      1, 0, 32'h40000000,   32'd4,        17, 32'h00000000, 1'b1);
        do_op("mul -5*-6",       1, 0, 32'hFFFFFFFB,   32'hFFFFFFFA, 17, 32'd30,       1'b0);
        do_op("mul max*-1",      1, 0, 32'h7FFFFFFF,   32'hFFFFFFFF, 17, 32'h80000001, 1'b0);
        do_op("mul min*min",     1, 0, 32'h80000000,   32'h80000000, 17, 32'h00000000, 1'b1);
        do_op("div -100/7",      0, 1, 32'hFFFFFF9C,   32'd7,        33, 32'hFFFFFFF2, 1'b0);
        do_op("div 5/0",         0, 1, 32'd5,          32'd0,        33, 32'd0,        1'b1);
        do_op("div min/-1",      0, 1, 32'h80000000,   32'hFFFFFFFF, 33, 32'h80000000, 1'b1);
        do_op("div 7/-2",        0, 1, 32'd7,          32'hFFFFFFFE, 33, 32'hFFFFFFFD, 1'b0);
        do_op("mul+div prio",    1, 1, 32'd6,          32'd7,        17, 32'd42,       1'b0);

        // Restart: MUL at E0, DIV at E5 -> single strobe at E38
        start_op(1, 0, 32'd9, 32'd9);
        watch(4, first, cnt);
        check("abort no strobe E1-4", 32'(cnt), 32'd0);
        start_op(0, 1, 32'd20, 32'd3);
        watch(40, first, cnt);
        check("abort strobe_edge", 32'(first + 5), 32'd38);
        check("abort strobe_count", 32'(cnt), 32'd1);
        check("abort result", bus.data_result, 32'd6);
        check("abort exception", 32'(bus.data_exception), 32'd0);
        $display("op abort mul->div 20/3 -> result=%h strobe@E%0d", bus.data_result, first + 5);

        // Reset at E10 of a DIV, with a start held during reset
        start_op(0, 1, 32'd1000, 32'd3);
        watch(10, first, cnt);
        reset = 1'b1;
        #1;
        check("areset result", bus.data_result, 32'd0);
        check("areset exception", 32'(bus.data_exception), 32'd0);
        check("areset rdy", 32'(bus.data_resultRDY), 32'd0);
        check("areset busy", 32'(bus.busy), 32'd0);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd50;
        bus.data_operandB = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.ctrl_DIV = 1'b0;
        reset        = 1'b0;
        watch(40, first, cnt);
        check("post-reset strobes", 32'(cnt), 32'd0);
        check("post-reset busy", 32'(bus.busy), 32'd0);
        $display("op reset@E10 of div -> strobes in 40 cycles=%0d", cnt);

        do_op("mul after reset", 1, 0, 32'd9, 32'd9, 17, 32'd81, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 Parameters: none; operand and result width fixed at 32 bits.
REQ-002 clk  input  1  single system clock, rising-edge active.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_operandA  input  32  multiplicand / dividend, two's complement.
REQ-005 data_operandB  input  32  multiplier / divisor, two's complement.
REQ-006 ctrl_MULT  input  1  start-multiply pulse, sampled on rising clk.
REQ-007 ctrl_DIV  input  1  start-divide pulse, sampled on rising clk.
REQ-008 data_result  output  32  product low word or quotient.
REQ-009 data_exception  output  1  overflow / divide-by-zero flag for data_result.
REQ-010 data_resultRDY  output  1  one-cycle completion strobe.
REQ-011 busy  output  1  high while an operation is in progress (states MUL, DIV).

Function
REQ-012 Start edge E0 = rising clk at which ctrl_MULT or ctrl_DIV is sampled high; operands SHALL be captured at E0 only, and later operand changes SHALL be ignored.
REQ-013 FSM states SHALL be IDLE, MUL, DIV, DONE: IDLE->MUL/DIV on start; MUL->DONE after 16 iterations; DIV->DONE after 32 iterations; DONE->IDLE after one cycle unless a new start arrives.
REQ-014 MUL SHALL use radix-4 modified Booth on a 66-bit working register {33-bit signed accumulator, 32-bit multiplier, 1 appended bit}, one iteration per cycle on E1..E16, with arithmetic shift right by 2 each iteration.
REQ-015 DIV SHALL use 32-iteration restoring division on operand magnitudes, one iteration per cycle on E1..E32, with quotient sign = signA XOR signB applied at finalize.
REQ-016 A 6-bit iteration counter SHALL be cleared at E0 and increment once per iteration.
REQ-017 data_resultRDY SHALL be high for exactly one cycle: from E17 to E18 for MUL, and from E33 to E34 for DIV.
REQ-018 MUL result SHALL be the low 32 bits of the signed 64-bit product; data_exception=1 iff the upper 32 bits are not the sign extension of bit 31.
REQ-019 DIV result SHALL be truncated toward zero; divisor 0 -> data_result=0, data_exception=1.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield data_result=0x80000000, data_exception=1.
REQ-021 data_result and data_exception SHALL update only when data_resultRDY rises and hold until the next completion.
REQ-022 A start in any state (IDLE, MUL, DIV, DONE) SHALL abort the current operation without asserting data_resultRDY and restart with the new operands; that edge becomes the new E0.
REQ-023 ctrl_MULT and ctrl_DIV high on the same edge: MUL SHALL take priority.
REQ-024 busy SHALL be high from E0 to the edge on which data_resultRDY rises, and low otherwise.

Reset
REQ-025 reset high SHALL immediately force: state IDLE, counter 0, working register 0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-026 reset during MUL/DIV SHALL abort the operation; no data_resultRDY SHALL follow.
REQ-027 Starts sampled while reset is high SHALL be ignored; the first start is accepted on the first rising clk after reset deasserts.

Verification
REQ-028 ctrl_MULT, A=7, B=-3 -> at E17: data_result=0xFFFFFFEB, data_exception=0, data_resultRDY high one cycle, busy low after.
REQ-029 ctrl_MULT, A=0x40000000, B=4 -> at E17: data_result=0x00000000, data_exception=1.
REQ-030 ctrl_DIV, A=-100, B=7 -> at E33: data_result=0xFFFFFFF2, data_exception=0; data_resultRDY low on E1..E32.
REQ-031 ctrl_DIV, A=5, B=0 -> at E33: data_result=0, data_exception=1.
REQ-032 ctrl_MULT (9x9) at E0, then ctrl_DIV A=20, B=3 at E5 -> no strobe at E17; strobe at E38 with data_result=6, data_exception=0.
REQ-033 reset pulsed at E10 of a DIV -> all outputs 0 asynchronously; no data_resultRDY for 40 following cycles.
